// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline control unit.
package pipe_ctrl_pkg;

  localparam int unsigned WCNT_W = 8;
  localparam int unsigned PERF_W = 32;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating stall / redirect-flush performance counters.
module pipe_ctrl_perf
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_inc,
  input  logic              flush_inc,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
      if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/stall/flush control for the 5-stage pipeline registers.
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN_REG = 5,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN_REG-1:0] id_rs1,
  input  logic [XLEN_REG-1:0] id_rs2,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic                ex_is_load,
  input  logic [XLEN_REG-1:0] ex_rd,
  input  logic                ex_redirect,
  input  logic                imem_ready,
  input  logic                mem_req,
  input  logic                mem_ack,
  output logic                pc_en,
  output logic                fd_en,
  output logic                fd_flush,
  output logic                dx_en,
  output logic                dx_flush,
  output logic                xm_en,
  output logic                mw_en,
  output logic                mw_flush,
  output logic                busy,
  output logic                mem_timeout,
  output logic [PERF_W-1:0]   stall_cnt,
  output logic [PERF_W-1:0]   flush_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_nxt;
  logic              timeout_set;
  logic              lu;
  logic              wait_hit;
  logic              freeze;

  assign lu = ex_is_load && (ex_rd != '0) &&
              ((id_rs1_used && (id_rs1 == ex_rd)) ||
               (id_rs2_used && (id_rs2 == ex_rd)));

  assign wait_hit = (wcnt == WCNT_W'(WAIT_MAX));

  // Whole pipe holds while a data access is outstanding; the timeout cycle releases.
  assign freeze = (state == RUN) ? (mem_req && !mem_ack)
                                 : (!mem_ack && !wait_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (timeout_set) mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = '0;
    timeout_set = 1'b0;
    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt = MEM_WAIT;
          wcnt_nxt  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end else begin
          state_nxt   = RUN;
          timeout_set = !mem_ack;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    fd_flush = 1'b0;
    dx_en    = 1'b1;
    dx_flush = 1'b0;
    xm_en    = 1'b1;
    mw_en    = 1'b1;
    mw_flush = 1'b0;
    busy     = 1'b0;
    if (rst) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      fd_flush = 1'b1;
      dx_en    = 1'b0;
      dx_flush = 1'b1;
      xm_en    = 1'b0;
      mw_en    = 1'b0;
      mw_flush = 1'b1;
    end else begin
      busy = (state == MEM_WAIT);
      if (freeze) begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        dx_en    = 1'b0;
        xm_en    = 1'b0;
        mw_en    = 1'b0;
        mw_flush = 1'b1;
      end else if (ex_redirect) begin
        fd_flush = 1'b1;
        dx_flush = 1'b1;
      end else if (lu) begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        dx_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_en    = 1'b0;
        fd_flush = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = !rst && !pc_en;
  assign flush_inc = !rst && !freeze && ex_redirect;

  pipe_ctrl_perf u_perf (
    .clk       (clk),
    .rst       (rst),
    .stall_inc (stall_inc),
    .flush_inc (flush_inc),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard scenarios followed by random traffic.
module tb_pipe_ctrl;

  localparam int unsigned WAIT_T = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       ld;
    logic [4:0] rd;
    logic       redir;
    logic       imr;
    logic       mreq;
    logic       mack;
  } stim_t;

  typedef enum int {A_RST, A_FREEZE, A_REDIR, A_LU, A_NOFETCH, A_NORM} act_t;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic        tmo;
    logic [31:0] sc;
    logic [31:0] fc;
    logic        known;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_is_load = 1'b0;
  logic        ex_redirect = 1'b0, imem_ready = 1'b1, mem_req = 1'b0, mem_ack = 1'b0;
  logic        pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, mw_en, mw_flush;
  logic        busy, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.XLEN_REG(5), .WAIT_MAX(WAIT_T)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .imem_ready(imem_ready),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
    .dx_en(dx_en), .dx_flush(dx_flush), .xm_en(xm_en),
    .mw_en(mw_en), .mw_flush(mw_flush),
    .busy(busy), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference model: pipeline is either flowing or waiting on memory.
  bit      m_wait   = 1'b0;
  int      m_waited = 0;
  bit      m_tmo    = 1'b0;
  bit      m_known  = 1'b0;
  longint  m_stall  = 0;
  longint  m_flush  = 0;

  // Control vector order: pc_en fd_en fd_flush dx_en dx_flush xm_en mw_en mw_flush busy
  function automatic logic [8:0] ctrl_of(input act_t a, input logic b);
    case (a)
      A_RST:     return 9'b0_0_1_0_1_0_0_1_0;
      A_FREEZE:  return {8'b0000_0001, b};
      A_REDIR:   return {8'b1111_1110, b};
      A_LU:      return {8'b0001_1110, b};
      A_NOFETCH: return {8'b0111_0110, b};
      default:   return {8'b1101_0110, b};
    endcase
  endfunction

  function automatic stim_t norm();
    stim_t s;
    s = '0;
    s.imr = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    act_t a;
    exp_t e;
    bit   hold;
    bit   load_use;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_rs1_used = s.u1; id_rs2_used = s.u2; ex_is_load = s.ld; ex_rd = s.rd;
    ex_redirect = s.redir; imem_ready = s.imr; mem_req = s.mreq; mem_ack = s.mack;

    load_use = s.ld && (s.rd != 0) &&
               ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (m_wait) hold = !s.mack && (m_waited < int'(WAIT_T));
    else        hold = s.mreq && !s.mack;

    if (s.rst)           a = A_RST;
    else if (hold)       a = A_FREEZE;
    else if (s.redir)    a = A_REDIR;
    else if (load_use)   a = A_LU;
    else if (!s.imr)     a = A_NOFETCH;
    else                 a = A_NORM;

    e.ctrl  = ctrl_of(a, !s.rst && m_wait);
    e.tmo   = m_tmo;
`ifdef PIPE_CTRL_PERF_EN
    e.sc    = 32'(m_stall);
    e.fc    = 32'(m_flush);
`else
    e.sc    = '0;
    e.fc    = '0;
`endif
    e.known = m_known;
    e.cyc   = cyc;
    sb.push_back(e);
    cyc++;

    if (s.rst) begin
      m_wait = 1'b0; m_waited = 0; m_tmo = 1'b0;
      m_stall = 0; m_flush = 0; m_known = 1'b1;
    end else begin
      if (a == A_FREEZE) begin
        m_waited = m_wait ? m_waited + 1 : 1;
        m_wait   = 1'b1;
      end else begin
        if (m_wait && !s.mack) m_tmo = 1'b1;
        m_wait = 1'b0; m_waited = 0;
      end
      if (!e.ctrl[8] && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (a == A_REDIR && m_flush < 64'hFFFF_FFFF) m_flush++;
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge clk) begin
    exp_t       e;
    logic [8:0] got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, mw_en, mw_flush, busy};
      n_chk++;
      if (got !== e.ctrl) begin
        n_fail++;
        $display("FAIL ctrl cyc=%0d got=%b exp=%b", e.cyc, got, e.ctrl);
      end
      if (e.known) begin
        n_chk++;
        if (mem_timeout !== e.tmo) begin
          n_fail++;
          $display("FAIL mem_timeout cyc=%0d got=%b exp=%b", e.cyc, mem_timeout, e.tmo);
        end
        n_chk++;
        if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
          n_fail++;
          $display("FAIL counters cyc=%0d got=%0d/%0d exp=%0d/%0d",
                   e.cyc, stall_cnt, flush_cnt, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    stim_t s;

    s = norm(); s.rst = 1'b1;
    repeat (2) step(s);
    repeat (2) step(norm());

    // Load-use on rs1, then same pattern with x0 as destination.
    s = norm(); s.ld = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
    step(s);
    step(norm());
    s.rd = 5'd0; s.rs1 = 5'd0;
    step(s);
    s = norm(); s.ld = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; s.u2 = 1'b1;
    step(s);

    // Redirect outranks load-use and fetch-not-ready.
    s = norm(); s.redir = 1'b1; s.ld = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3; s.u1 = 1'b1; s.imr = 1'b0;
    step(s);
    step(norm());

    // Access acked on its fourth cycle.
    s = norm(); s.mreq = 1'b1;
    repeat (3) step(s);
    s.mack = 1'b1;
    step(s);
    step(norm());

    // Same-cycle ack: no stall.
    s = norm(); s.mreq = 1'b1; s.mack = 1'b1;
    step(s);

    // Fetch not ready for two cycles.
    s = norm(); s.imr = 1'b0;
    repeat (2) step(s);
    step(norm());

    // Redirect raised while frozen applies on the release cycle.
    s = norm(); s.mreq = 1'b1; s.redir = 1'b1;
    repeat (2) step(s);
    s.mack = 1'b1;
    step(s);

    // Timeout: ack never comes.
    s = norm(); s.mreq = 1'b1;
    repeat (5) step(s);
    repeat (4) step(norm());

    // Reset in the middle of a wait.
    s = norm(); s.mreq = 1'b1;
    repeat (2) step(s);
    s.rst = 1'b1;
    step(s);
    repeat (2) step(norm());

    for (int i = 0; i < 3000; i++) begin
      s = norm();
      s.rst   = ($urandom_range(0, 199) == 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.rd    = 5'($urandom_range(0, 3));
      s.u1    = ($urandom_range(0, 1) == 0);
      s.u2    = ($urandom_range(0, 1) == 0);
      s.ld    = ($urandom_range(0, 2) == 0);
      s.redir = ($urandom_range(0, 7) == 0);
      s.imr   = ($urandom_range(0, 3) != 0);
      s.mreq  = ($urandom_range(0, 5) == 0);
      s.mack  = ($urandom_range(0, 2) == 0);
      step(s);
    end

    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
